div_16: RTL and testbench

//   Sequential unsigned divider: the inverse companion of the mult_8/mult_16 DSP cells in this techlib.

---
 rtl/div_16.sv | 106 ++++++++++
 tb/tb_div_16.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/div_16.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// MODE=0 performs a 16-bit divide; MODE=1 performs an 8-bit divide on the low byte.
module div_16 #(
  parameter bit MODE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [0:15] a,
  input  logic [0:15] b,
  output logic        busy,
  output logic        done,
  output logic [0:15] q,
  output logic [0:15] r,
  output logic        div0
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 5;
  localparam int unsigned N  = MODE ? 8 : 16;
  localparam logic [W-1:0] MASK = MODE ? 16'h00FF : 16'hFFFF;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state;
  logic [W-1:0]    dvd;
  logic [W-1:0]    dvs;
  logic [W-1:0]    rem;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    am;
  logic [W-1:0]    bm;
  logic [W:0]      rem_sh;
  logic            ge;
  logic [W-1:0]    rem_nx;
  logic [W-1:0]    dvd_nx;

  // Dividend register doubles as the quotient register: bits leave at the MSB
  // into the partial remainder while quotient bits enter at the LSB.
  always_comb begin
    am     = a & MASK;
    bm     = b & MASK;
    rem_sh = {rem, dvd[W-1]};
    ge     = rem_sh >= {1'b0, dvs};
    rem_nx = ge ? (rem_sh[W-1:0] - dvs) : rem_sh[W-1:0];
    dvd_nx = {dvd[W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      div0  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (start) begin
            // 8-bit operands are left-aligned so the MSB is always bit W-1
            dvd <= W'(am << (W - N));
            dvs <= bm;
            rem <= '0;
            cnt <= CW'(N);
            if (bm == '0) begin
              state <= FIN;
              done  <= 1'b1;
              div0  <= 1'b1;
              q     <= MASK;
              r     <= am;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd <= dvd_nx;
          rem <= rem_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            div0  <= 1'b0;
            q     <= dvd_nx;
            r     <= rem_nx;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_16.sv
// Scoreboard bench for div_16: one 16-bit and one 8-bit instance driven in parallel,
// expected quotient/remainder/latency computed with plain arithmetic.
module tb_div_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [2];
  logic [0:15] a     [2];
  logic [0:15] b     [2];
  logic        busy  [2];
  logic        done  [2];
  logic        div0  [2];
  logic [0:15] q     [2];
  logic [0:15] r     [2];

  always #5 clk = ~clk;

  div_16 #(.MODE(1'b0)) u_div16 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a[0]), .b(b[0]),
    .busy(busy[0]), .done(done[0]), .q(q[0]), .r(r[0]), .div0(div0[0])
  );

  div_16 #(.MODE(1'b1)) u_div8 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a[1]), .b(b[1]),
    .busy(busy[1]), .done(done[1]), .q(q[1]), .r(r[1]), .div0(div0[1])
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        d0;
    int          due;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   edge_n = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", nm, i, act, exp, $time);
    end
  endfunction

  // Monitor: every DONE pulse must match the oldest outstanding request
  task automatic mon(input int i);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (i == 0) begin
      if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
    end else begin
      if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
    end
    if (!have) begin
      chk("unexpected_done", i, 32'd1, 32'd0);
    end else begin
      chk("q", i, 32'(q[i]), 32'(e.q));
      chk("r", i, 32'(r[i]), 32'(e.r));
      chk("div0", i, 32'(div0[i]), 32'(e.d0));
      chk("latency_edge", i, 32'(edge_n), 32'(e.due));
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (rst_n === 1'b1 && done[i] === 1'b1) mon(i);
  end

  // Drive a request at the current negedge and record its expected outcome
  task automatic issue(input int i, input logic [15:0] av, input logic [15:0] bv);
    exp_t        e;
    logic [15:0] m;
    logic [15:0] am;
    logic [15:0] bm;
    m  = (i == 0) ? 16'hFFFF : 16'h00FF;
    am = av & m;
    bm = bv & m;
    start[i] = 1'b1;
    a[i]     = av;
    b[i]     = bv;
    if (bm == 16'd0) begin
      e.q = m; e.r = am; e.d0 = 1'b1; e.due = edge_n + 1;
    end else begin
      e.q = am / bm; e.r = am % bm; e.d0 = 1'b0;
      e.due = edge_n + 1 + ((i == 0) ? 16 : 8);
    end
    if (i == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  // Wait for DONE, optionally poking START mid-calculation; returns at the DONE negedge
  task automatic finish_op(input int i, input int exp_busy, input int poke);
    int bc;
    bit seen;
    bc   = 0;
    seen = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      start[i] = (k == poke);
      if (k == poke) begin
        a[i] = 16'($urandom);
        b[i] = 16'($urandom_range(1, 65535));
      end else if (k == 0) begin
        a[i] = 16'($urandom);
        b[i] = 16'($urandom);
      end
      if (busy[i] === 1'b1) bc++;
      if (done[i] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start[i] = 1'b0;
    if (!seen) chk("timeout", i, 32'd0, 32'd1);
    else       chk("busy_cycles", i, 32'(bc), 32'(exp_busy));
  endtask

  task automatic check_zero(input int i);
    chk("rst_busy", i, 32'(busy[i]), 32'd0);
    chk("rst_done", i, 32'(done[i]), 32'd0);
    chk("rst_div0", i, 32'(div0[i]), 32'd0);
    chk("rst_q",    i, 32'(q[i]),    32'd0);
    chk("rst_r",    i, 32'(r[i]),    32'd0);
  endtask

  task automatic rnd(input int i, input int count);
    logic [15:0] av;
    logic [15:0] bv;
    logic [15:0] m;
    m = (i == 0) ? 16'hFFFF : 16'h00FF;
    for (int n = 0; n < count; n++) begin
      av = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       bv = 16'($urandom) & ~m;
        1:       bv = 16'($urandom_range(1, 15));
        default: bv = 16'($urandom);
      endcase
      issue(i, av, bv);
      finish_op(i, ((bv & m) == 16'd0) ? 0 : ((i == 0) ? 16 : 8),
                ($urandom_range(0, 9) == 0) ? 2 : -1);
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      a[i]     = '0;
      b[i]     = '0;
    end
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed 16-bit cases, issued back-to-back in the FIN cycle
    issue(0, 16'd1000, 16'd7);     finish_op(0, 16, -1);
    issue(0, 16'hFFFF, 16'd1);     finish_op(0, 16, -1);
    issue(0, 16'd5, 16'hFFFF);     finish_op(0, 16, -1);
    issue(0, 16'd1234, 16'd0);     finish_op(0, 0, -1);
    issue(0, 16'd9, 16'd3);        finish_op(0, 16, -1);
    issue(0, 16'd500, 16'd13);     finish_op(0, 16, 3);

    // Directed 8-bit cases, upper operand bytes must be ignored
    issue(1, 16'hABC8, 16'h7709);  finish_op(1, 8, -1);
    issue(1, 16'h1234, 16'hAB00);  finish_op(1, 0, -1);
    issue(1, 16'h00FF, 16'h0001);  finish_op(1, 8, -1);
    issue(1, 16'h5507, 16'hFFFF);  finish_op(1, 8, 4);
    repeat (2) @(negedge clk);

    // Reset in the middle of a calculation discards it
    issue(0, 16'd40000, 16'd3);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero(0);
    check_zero(1);
    sb0.delete();
    sb1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(0, 16'd40000, 16'd3);    finish_op(0, 16, -1);
    repeat (2) @(negedge clk);

    fork
      rnd(0, 2500);
      rnd(1, 2500);
    join

    repeat (3) @(negedge clk);
    chk("pending", 0, 32'(sb0.size()), 32'd0);
    chk("pending", 1, 32'(sb1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
